// File: rtl/latch_q_capture.sv
// Clocked capture of a level-sensitive latch bank: sync en/q, snapshot on every close, stream out via FIFO.
// Latency: close first sampled at edge k -> push at edge k+SYNC_STAGES+1; a capture meeting a full FIFO with no pop is dropped (sticky overflow).
module latch_q_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter bit CHANGE_ONLY = 1'b0,
  parameter bit EN_INVERT   = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         latch_en,
  input  logic [WIDTH-1:0]             latch_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  typedef enum logic [1:0] {ST_CLOSED, ST_OPEN, ST_SETTLE} state_t;

  logic                   en_raw;
  logic [SYNC_STAGES-1:0] en_sync;
  logic [WIDTH-1:0]       q_sync [SYNC_STAGES];
  logic                   en_s;
  logic [WIDTH-1:0]       q_s;

  state_t                 state, state_nxt;
  logic                   cap_vld;
  logic [WIDTH-1:0]       last_cap;
  logic                   last_vld;
  logic                   dup;
  logic                   push_vld;
  logic                   push_rdy;

  assign en_raw = latch_en ^ EN_INVERT;
  assign en_s   = en_sync[SYNC_STAGES-1];
  assign q_s    = q_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) q_sync[i] <= '0;
    end else begin
      en_sync   <= {en_sync[SYNC_STAGES-2:0], en_raw};
      q_sync[0] <= latch_q;
      for (int i = 1; i < SYNC_STAGES; i++) q_sync[i] <= q_sync[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLOSED;
    else     state <= state_nxt;
  end

  // SETTLE always captures, even if the enable has already re-opened.
  always_comb begin
    state_nxt = state;
    cap_vld   = 1'b0;
    case (state)
      ST_CLOSED: if (en_s) state_nxt = ST_OPEN;
      ST_OPEN:   if (!en_s) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        cap_vld   = 1'b1;
        state_nxt = en_s ? ST_OPEN : ST_CLOSED;
      end
      default:   state_nxt = ST_CLOSED;
    endcase
  end

  assign dup      = CHANGE_ONLY && last_vld && (q_s == last_cap);
  assign push_vld = cap_vld && !dup;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_cap <= '0;
      last_vld <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (cap_vld) begin
        last_cap <= q_s;
        last_vld <= 1'b1;
      end
      if (push_vld && !push_rdy) overflow <= 1'b1;
    end
  end

  latch_q_capture_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (q_s),
    .push_rdy (push_rdy),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_data),
    .level    (level)
  );

endmodule

// Generic FIFO with a registered head; pop_dat holds its last value when empty.
// Latency 1 (push visible next cycle); push_rdy drops only when full with no pop in the same cycle.
module latch_q_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       push_rdy,
  output logic                       pop_vld,
  input  logic                       pop_rdy,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, head_idx;
  logic [LW-1:0]    count, count_nxt;
  logic             push, pop;

  assign pop       = (count != '0) && pop_rdy;
  assign push_rdy  = (count != LW'(DEPTH)) || pop;
  assign push      = push_vld && push_rdy;
  assign head_idx  = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign count_nxt = count + LW'(push) - LW'(pop);
  assign pop_vld   = (count != '0);
  assign level     = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // The next head is the incoming word only when it lands in the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pop_dat <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (push && head_idx == wr_ptr) pop_dat <= push_dat;
      else if (count_nxt != '0)       pop_dat <= mem[head_idx];
    end
  end

endmodule
